mem_port_arbiter: RTL and testbench

- Shares one single-port memory between the core's instruction-fetch port (read-only) and data port (read/write), so the core can move from the dual-port memory model to a shared-memory, multi-cycle model.
- Accepts one request at a time and sequences it through issue, wait and response phases.
- On simultaneous requests, grants round-robin.
- Sits between the core and the memory module.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_arbiter2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF = 32;

  // Transaction sequencing states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Port identity, used both for the transaction owner and the last grant.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant history lives in the parent.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_grant,
  output logic [1:0] gnt          // bit 0 = instruction port, bit 1 = data port
);

  // Single requester wins outright; on conflict the port not granted last wins.
  always_comb begin
    gnt = 2'b00;
    if (req_i && req_d) begin
      gnt = (last_grant == OWNER_D) ? 2'b01 : 2'b10;
    end else if (req_i) begin
      gnt = 2'b01;
    end else if (req_d) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the data port,
// one transaction at a time: grant, issue, wait for data, respond.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_LEN-1:0] i_addr,
  output logic                i_ready,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                mem_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                busy
);

  logic [1:0]          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                wen_q, wen_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_LEN-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]          gnt;
  logic                idle;

  assign idle = (state_q == ST_IDLE);

  // Requests are only eligible while idle, so readys are zero in every other state.
  rr_arbiter2 u_arb (
    .req_i      (i_req & idle),
    .req_d      (d_req & idle),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Next-state and datapath capture for one transaction at a time.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d      = ST_ISSUE;
          owner_d      = gnt[1] ? OWNER_D : OWNER_I;
          last_grant_d = owner_d;
          addr_d       = gnt[1] ? d_addr : i_addr;
          wen_d        = gnt[1] & d_wen;
          // Fetches carry no write data, so the bus keeps its last value.
          if (gnt[1]) begin
            wdata_d = d_wdata;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_I) begin
            i_rdata_d = mem_rdata;
          end else if (!wen_q) begin
            // A write ack carries no load data; d_rdata keeps its last value.
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured fields; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWNER_D;
      owner_q      <= OWNER_I;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_ready   = gnt[0];
  assign d_ready   = gnt[1];
  assign mem_req   = (state_q == ST_ISSUE);
  assign mem_wen   = mem_req & wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rvalid  = (state_q == ST_RESP) && (owner_q == OWNER_I);
  assign d_rvalid  = (state_q == ST_RESP) && (owner_q == OWNER_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, i_rvalid, d_ready, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wen, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference model: one outstanding transaction described by what has happened to it.
  bit          m_active, m_accepted, m_returned, m_owner_d, m_wen, m_last_d;
  logic [31:0] m_last_addr, m_last_wdata, m_i_rdata, m_d_rdata;
  bit          g_i, g_d;      // model grant in the most recent step
  bit          dut_log[$];    // 1 = data port granted, as observed on the DUT readys

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_accepted = 0; m_returned = 0; m_owner_d = 0; m_wen = 0;
    m_last_d = 1; m_last_addr = '0; m_last_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
    g_i = 0; g_d = 0;
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_wen = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Called at a falling edge with inputs applied: checks outputs, advances model one cycle.
  task automatic step();
    bit e_i, e_d;
    #1;
    e_i = !m_active && i_req && (!d_req || m_last_d);
    e_d = !m_active && d_req && (!i_req || !m_last_d);
    check_eq("i_ready", i_ready, e_i);
    check_eq("d_ready", d_ready, e_d);
    check_eq("busy", busy, m_active);
    check_eq("mem_req", mem_req, m_active && !m_accepted);
    check_eq("mem_wen", mem_wen, m_active && !m_accepted && m_wen);
    check_eq("mem_addr", mem_addr, m_last_addr);
    check_eq("mem_wdata", mem_wdata, m_last_wdata);
    check_eq("i_rvalid", i_rvalid, m_active && m_returned && !m_owner_d);
    check_eq("d_rvalid", d_rvalid, m_active && m_returned && m_owner_d);
    check_eq("i_rdata", i_rdata, m_i_rdata);
    check_eq("d_rdata", d_rdata, m_d_rdata);
    if (i_ready || d_ready) dut_log.push_back(d_ready);
    g_i = 0; g_d = 0;
    if (m_active && m_returned) begin
      n_txn++;
      $display("txn %0d: %s %s addr=%h data=%h", n_txn, m_owner_d ? "D" : "I",
               m_wen ? "write" : "read ", m_last_addr,
               m_wen ? m_last_wdata : (m_owner_d ? m_d_rdata : m_i_rdata));
      m_active = 0;
    end else if (m_active && m_accepted) begin
      if (mem_rvalid) begin
        m_returned = 1;
        if (!m_owner_d) m_i_rdata = mem_rdata;
        else if (!m_wen) m_d_rdata = mem_rdata;
      end
    end else if (m_active) begin
      if (mem_ready) m_accepted = 1;
    end else if (e_i || e_d) begin
      m_active = 1; m_accepted = 0; m_returned = 0;
      m_owner_d = e_d;
      m_wen = e_d && d_wen;
      m_last_addr = e_d ? d_addr : i_addr;
      if (e_d) m_last_wdata = d_wdata;
      m_last_d = e_d;
      g_i = e_i; g_d = e_d;
    end
    @(negedge clk);
  endtask

  // Memory responder that always accepts and answers as soon as it may.
  task automatic mem_auto();
    mem_rvalid = m_active && m_accepted && !m_returned;
    mem_ready  = !mem_rvalid;
    mem_rdata  = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    check_eq("rst_i_ready", i_ready, 0);   check_eq("rst_d_ready", d_ready, 0);
    check_eq("rst_i_rvalid", i_rvalid, 0); check_eq("rst_d_rvalid", d_rvalid, 0);
    check_eq("rst_i_rdata", i_rdata, 0);   check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_mem_req", mem_req, 0);   check_eq("rst_mem_wen", mem_wen, 0);
    check_eq("rst_mem_addr", mem_addr, 0); check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_busy", busy, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  // Run one request to completion; ready_delay holds mem_ready low in ISSUE.
  task automatic run_txn(input bit is_d, input logic [31:0] addr, input bit wen,
                         input logic [31:0] wdata, input int ready_delay);
    int  n;
    bit  granted;
    idle_inputs();
    if (is_d) begin d_req = 1; d_addr = addr; d_wen = wen; d_wdata = wdata; end
    else begin i_req = 1; i_addr = addr; end
    granted = 0; n = 0;
    while (!granted && n < 20) begin
      step(); n++;
      granted = g_i || g_d;
    end
    check_eq("grant_seen", granted, 1);
    i_req = 0; d_req = 0;
    n = 0;
    while (m_active && n < 50) begin
      mem_auto();
      if (m_active && !m_accepted && ready_delay > 0) begin
        mem_ready = 0; ready_delay--;
      end
      step(); n++;
    end
    check_eq("txn_done", m_active, 0);
    idle_inputs();
  endtask

  task automatic rand_inputs();
    bit waiting;
    if (g_i) i_req = 0;
    if (g_d) d_req = 0;
    if (!i_req) begin
      if ($urandom_range(0, 99) < 30) begin i_req = 1; i_addr = 32'($urandom_range(0, 63)) << 2; end
    end else if ($urandom_range(0, 99) < 4) i_req = 0;
    if (!d_req) begin
      if ($urandom_range(0, 99) < 30) begin
        d_req = 1; d_addr = 32'($urandom_range(0, 63)) << 2;
        d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
    end else if ($urandom_range(0, 99) < 4) d_req = 0;
    waiting = m_active && m_accepted && !m_returned;
    mem_rvalid = waiting ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
    mem_ready  = mem_rvalid ? 1'b0 : ($urandom_range(0, 99) < 60);
    mem_rdata  = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
    do_reset();

    // Single fetch with minimum latency.
    i_req = 1; i_addr = 32'h8; mem_ready = 1;
    step();                                           // cycle 0: grant
    check_eq("fetch_grant", g_i, 1);
    i_req = 0;
    step();                                           // cycle 1: ISSUE accepted
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00002003;
    step();                                           // cycle 2: data returns
    mem_rvalid = 0;
    step();                                           // cycle 3: i_rvalid pulse
    check_eq("fetch_rdata", i_rdata, 32'h00002003);
    step();

    // Sustained conflict after reset alternates I, D, I, D.
    do_reset();
    dut_log.delete();
    i_req = 1; i_addr = 32'h4; d_req = 1; d_addr = 32'h100; d_wen = 0;
    for (int c = 0; c < 16; c++) begin mem_auto(); step(); end
    idle_inputs();
    check_eq("conflict_count", dut_log.size(), 4);
    for (int k = 0; k < 4 && k < dut_log.size(); k++)
      check_eq($sformatf("conflict_order%0d", k), dut_log[k], k % 2);

    // Store, then a fetch under 5 cycles of memory backpressure.
    run_txn(1'b1, 32'h40, 1'b1, 32'hDEADBEEF, 0);
    run_txn(1'b0, 32'h80, 1'b0, 32'h0, 5);
    run_txn(1'b1, 32'h44, 1'b0, 32'h0, 5);

    // Reset while waiting for data, then a stale response.
    idle_inputs();
    i_req = 1; i_addr = 32'h20; mem_ready = 1;
    step();
    i_req = 0;
    step();
    mem_ready = 0;
    step();                                           // now waiting for data
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h0BAD0BAD;
    step();
    mem_rvalid = 0;
    step(); step();
    run_txn(1'b0, 32'h24, 1'b0, 32'h0, 0);

    // Data request pulsed for one cycle while a fetch waits: withdrawn.
    idle_inputs();
    dut_log.delete();
    i_req = 1; i_addr = 32'h30; mem_ready = 1;
    step();
    i_req = 0;
    step();
    mem_ready = 0;
    d_req = 1; d_addr = 32'h200; d_wen = 1; d_wdata = 32'h12345678;
    step();
    d_req = 0;
    n = 0;
    while (m_active && n < 20) begin mem_auto(); step(); n++; end
    idle_inputs();
    for (int c = 0; c < 6; c++) step();
    check_eq("withdraw_grants", dut_log.size(), 1);

    // Randomized traffic with spurious responses and random backpressure.
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
